// File: rtl/disparity_select.sv
// Winner-take-all disparity selection: 8-cycle pipelined min-tree over DISP_RANGE cost lanes.
// Optional build macro UNIQUENESS_CHECK_EN adds second-best tracking and a uniqueness reject.
module disparity_select #(
    parameter int MIN_DISP     = 20,
    parameter int DISP_RANGE   = 108,
    parameter int PIX_W        = 8,
    parameter int INVALID_DISP = 0,
    parameter int UNIQ_RATIO   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DISP_RANGE*PIX_W-1:0]   cost_aggr,
    input  logic [9:0]                    row,
    input  logic [9:0]                    col,
    output logic [7:0]                    disp,
    output logic [PIX_W-1:0]              min_cost,
    output logic [9:0]                    out_row,
    output logic [9:0]                    out_col,
    output logic                          valid
);

    localparam int LEVELS = $clog2(DISP_RANGE);
    localparam int IDX_W  = $clog2(DISP_RANGE);

    function automatic int lanes_at(input int l);
        int n;
        n = DISP_RANGE;
        for (int k = 0; k < l; k++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic int offset_at(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) o += lanes_at(k);
        return o;
    endfunction

    // All tree levels share one flat node array; level l starts at offset_at(l).
    localparam int ROOT  = offset_at(LEVELS);
    localparam int NODES = ROOT + 1;

    typedef struct packed {
        logic [PIX_W-1:0] cost;
        logic [IDX_W-1:0] idx;
`ifdef UNIQUENESS_CHECK_EN
        logic [PIX_W-1:0] sec;
`endif
    } node_t;

    function automatic node_t merge(input node_t a, input node_t b);
        node_t r;
`ifdef UNIQUENESS_CHECK_EN
        logic [PIX_W-1:0] hi;
`endif
        // Strict less-than keeps the lower-index (a) side on ties.
        r = (b.cost < a.cost) ? b : a;
`ifdef UNIQUENESS_CHECK_EN
        hi = (a.cost > b.cost) ? a.cost : b.cost;
        if (a.sec < hi) hi = a.sec;
        if (b.sec < hi) hi = b.sec;
        r.sec = hi;
`endif
        return r;
    endfunction

    node_t node_d [NODES];
    node_t node_q [NODES];

    logic [LEVELS:0] en_d, en_q;
    logic [9:0]      row_d [LEVELS+1];
    logic [9:0]      row_q [LEVELS+1];
    logic [9:0]      col_d [LEVELS+1];
    logic [9:0]      col_q [LEVELS+1];

    logic [7:0]       disp_d, disp_q;
    logic [PIX_W-1:0] min_cost_d, min_cost_q;
    logic [9:0]       out_row_d, out_row_q;
    logic [9:0]       out_col_d, out_col_q;
    logic             valid_d, valid_q;
    logic             reject;
    node_t            root;

    always_comb begin
        node_d = '{default: '0};
        for (int j = 0; j < DISP_RANGE; j++) begin
            node_d[j].cost = cost_aggr[PIX_W*j +: PIX_W];
            node_d[j].idx  = IDX_W'(j);
`ifdef UNIQUENESS_CHECK_EN
            node_d[j].sec  = '1;
`endif
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int j = 0; j < DISP_RANGE; j++) begin
                if (j < lanes_at(l)) begin
                    if (2*j + 1 < lanes_at(l-1))
                        node_d[offset_at(l)+j] = merge(node_q[offset_at(l-1)+2*j],
                                                       node_q[offset_at(l-1)+2*j+1]);
                    else
                        node_d[offset_at(l)+j] = node_q[offset_at(l-1)+2*j];
                end
            end
        end
    end

    always_comb begin
        en_d     = {en_q[LEVELS-1:0], en};
        row_d[0] = row;
        col_d[0] = col;
        for (int k = 1; k <= LEVELS; k++) begin
            row_d[k] = row_q[k-1];
            col_d[k] = col_q[k-1];
        end
    end

    always_comb begin
        root       = node_q[ROOT];
        reject     = (root.cost == '1);
`ifdef UNIQUENESS_CHECK_EN
        if (16'(root.cost) * 16'(100 + UNIQ_RATIO) > 16'(root.sec) * 16'(100))
            reject = 1'b1;
`endif
        disp_d     = reject ? 8'(INVALID_DISP) : 8'(MIN_DISP) + 8'(root.idx);
        min_cost_d = root.cost;
        out_row_d  = row_q[LEVELS];
        out_col_d  = col_q[LEVELS];
        valid_d    = en_q[LEVELS];
    end

    // Cost/index datapath needs no reset: its contents are qualified by the en chain.
    always_ff @(posedge clk) begin
        node_q <= node_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= '0;
            row_q      <= '{default: '0};
            col_q      <= '{default: '0};
            disp_q     <= '0;
            min_cost_q <= '1;
            out_row_q  <= '0;
            out_col_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            en_q       <= en_d;
            row_q      <= row_d;
            col_q      <= col_d;
            disp_q     <= disp_d;
            min_cost_q <= min_cost_d;
            out_row_q  <= out_row_d;
            out_col_q  <= out_col_d;
            valid_q    <= valid_d;
        end
    end

    assign disp     = disp_q;
    assign min_cost = min_cost_q;
    assign out_row  = out_row_q;
    assign out_col  = out_col_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_disparity_select.sv
// Directed self-checking bench for disparity_select; honours UNIQUENESS_CHECK_EN when defined.
module tb_disparity_select;

    localparam int NL = 108;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NL*8-1:0] cost_aggr;
    logic [9:0]    row, col;
    logic [7:0]    disp, min_cost;
    logic [9:0]    out_row, out_col;
    logic          valid;

    logic [NL*8-1:0] vec;
    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       v;
        logic [9:0] r;
        logic [9:0] c;
        logic [7:0] d;
        logic [7:0] m;
    } exp_t;

    exp_t hist [9];

    disparity_select dut (
        .clk(clk), .rst(rst), .en(en), .cost_aggr(cost_aggr),
        .row(row), .col(col), .disp(disp), .min_cost(min_cost),
        .out_row(out_row), .out_col(out_col), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NL; i++) vec[8*i +: 8] = v;
    endtask

    task automatic set_lane(input int i, input logic [7:0] v);
        vec[8*i +: 8] = v;
    endtask

    // One clock: apply inputs, then compare outputs with the entry sampled 8 edges earlier.
    task automatic step(input logic e, input logic [9:0] r, input logic [9:0] c,
                        input logic [7:0] xd, input logic [7:0] xm);
        @(negedge clk);
        en = e; row = r; col = c; cost_aggr = vec;
        @(posedge clk);
        #1;
        for (int k = 8; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = '{v: e, r: r, c: c, d: xd, m: xm};
        chk("valid", 32'(valid), 32'(hist[8].v));
        if (hist[8].v) begin
            chk("disp", 32'(disp), 32'(hist[8].d));
            chk("min_cost", 32'(min_cost), 32'(hist[8].m));
            chk("out_row", 32'(out_row), 32'(hist[8].r));
            chk("out_col", 32'(out_col), 32'(hist[8].c));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) hist[k] = '0;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 8'd0, 8'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; row = '0; col = '0; vec = '0; cost_aggr = '0;
        for (int k = 0; k < 9; k++) hist[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_disp", 32'(disp), 32'd0);
        chk("rst_min_cost", 32'(min_cost), 32'd255);
        chk("rst_out_row", 32'(out_row), 32'd0);
        chk("rst_out_col", 32'(out_col), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single winner in the middle of the range
        fill(8'd200); set_lane(37, 8'd5);
        step(1'b1, 10'd3, 10'd9, 8'd57, 8'd5);
        // Tie between lanes 10 and 80: lower index wins (rejected when uniqueness is on)
        fill(8'd50); set_lane(10, 8'd7); set_lane(80, 8'd7);
`ifdef UNIQUENESS_CHECK_EN
        step(1'b1, 10'd4, 10'd0, 8'd0, 8'd7);
`else
        step(1'b1, 10'd4, 10'd0, 8'd30, 8'd7);
`endif
        // Fully saturated pixel
        fill(8'hFF);
        step(1'b1, 10'd5, 10'd1, 8'd0, 8'd255);
        // Uniqueness vectors: close second, clear second, odd pass-through lane 107
        fill(8'hFF); set_lane(0, 8'd100); set_lane(50, 8'd105);
`ifdef UNIQUENESS_CHECK_EN
        step(1'b1, 10'd6, 10'd2, 8'd0, 8'd100);
`else
        step(1'b1, 10'd6, 10'd2, 8'd20, 8'd100);
`endif
        set_lane(50, 8'd120);
        step(1'b1, 10'd7, 10'd3, 8'd20, 8'd100);
        fill(8'hFF); set_lane(107, 8'd1);
        step(1'b1, 10'd1023, 10'd1023, 8'd127, 8'd1);
        // Lane 0 winner with cost 0, column 0
        fill(8'd9); set_lane(0, 8'd0);
        step(1'b1, 10'd8, 10'd0, 8'd20, 8'd0);
        // Winner at the last lane with a single-step margin
        fill(8'd201); set_lane(107, 8'd200);
`ifdef UNIQUENESS_CHECK_EN
        step(1'b1, 10'd9, 10'd4, 8'd0, 8'd200);
`else
        step(1'b1, 10'd9, 10'd4, 8'd127, 8'd200);
`endif
        idle(8);

        // Back-to-back stream with en pattern 1,1,0
        for (int k = 0; k < 20; k++) begin
            fill(8'd100); set_lane(k, 8'(k + 1));
            step((k % 3) != 2, 10'(k), 10'(k + 1), 8'(20 + k), 8'(k + 1));
        end
        idle(8);

        // Reset with five pixels in flight
        for (int k = 0; k < 5; k++) begin
            fill(8'd90); set_lane(60 + k, 8'd4);
            step(1'b1, 10'(100 + k), 10'(200 + k), 8'(80 + k), 8'd4);
        end
        do_reset();
        idle(8);
        fill(8'd90); set_lane(2, 8'd11);
        step(1'b1, 10'd55, 10'd66, 8'd22, 8'd11);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
